// File: rtl/param_table_seq.sv
// param_table_seq: streams the entries of a packed constant table, one entry
// per valid/ready beat, across NUM_CH parallel channels of WIDTH bits each.
// Supports start/abort control and a loop mode that wraps to entry 0.
// Optional checks: define PARAM_TABLE_SEQ_ASSERT_EN to compile in parameter
// and protocol assertions; behaviour is identical with or without it.
module param_table_seq #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 4,
   parameter logic [DEPTH*NUM_CH*WIDTH-1:0] TABLE = '0,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    loop_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM_CH*WIDTH-1:0] out_data,
   output logic                    out_last,
   output logic [IW-1:0]           idx,
   output logic                    busy
);

   localparam int            ROW      = NUM_CH * WIDTH;
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IW-1:0]   r_idx;
   logic [IW-1:0]   w_idx_nxt;
   logic [IW-1:0]   w_idx_inc;
   logic [ROW-1:0]  r_data;
   logic [ROW-1:0]  w_data_nxt;
   logic            w_beat;
   logic            w_at_last;

   // Constant-width slice of one table row; callers only pass indices < DEPTH.
   function automatic logic [ROW-1:0] entry_at(input logic [IW-1:0] e);
      return TABLE[int'(e)*ROW +: ROW];
   endfunction

   assign w_beat    = (r_state == S_RUN) && out_ready;
   assign w_at_last = (r_idx == LAST_IDX);
   assign w_idx_inc = r_idx + 1'b1;

   // Next-state, next-index and next-entry decode for the IDLE/RUN sequencer.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_data_nxt  = r_data;
      case (r_state)
         S_IDLE: begin
            // abort has priority over a simultaneous start
            if (start && !abort) begin
               w_state_nxt = S_RUN;
               w_idx_nxt   = '0;
               w_data_nxt  = entry_at('0);
            end
         end
         S_RUN: begin
            if (w_beat) begin
               if (!w_at_last) begin
                  w_idx_nxt  = w_idx_inc;
                  w_data_nxt = entry_at(w_idx_inc);
               end else if (loop_en) begin
                  w_idx_nxt  = '0;
                  w_data_nxt = entry_at('0);
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            // a beat in the abort cycle is still consumed above
            if (abort) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, index and output-entry registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the entry register is reset too, so no stale data survives a reset.
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_data  <= w_data_nxt;
      end
   end

   assign busy      = (r_state == S_RUN);
   assign out_valid = busy;
   assign out_data  = r_data;
   assign idx       = r_idx;
   assign out_last  = busy && w_at_last;

`ifdef PARAM_TABLE_SEQ_ASSERT_EN
   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("param_table_seq: NUM_CH must be >= 1");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("param_table_seq: WIDTH must be >= 1");
   end
   if (DEPTH < 1) begin : g_bad_depth
      $error("param_table_seq: DEPTH must be >= 1");
   end

   a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
      int'(r_idx) < DEPTH);

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> ($stable(out_data) && $stable(idx)));

   a_valid_busy: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid == busy);
`endif

endmodule

// File: tb/tb_param_table_seq.sv
// Testbench for param_table_seq: directed scenarios plus a randomized run
// compared against a table-level behavioural model of the sequencer.
module tb_param_table_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0, loop_en = 1'b0, out_ready = 1'b0;
   logic        out_valid, out_last, busy;
   logic [15:0] out_data;
   logic [1:0]  idx;

   // DEPTH=1 instance
   logic        s1 = 1'b0;
   logic        d1_valid, d1_last, d1_busy;
   logic [15:0] d1_data;
   logic [0:0]  d1_idx;

   // default all-zero table instance
   logic        s0 = 1'b0;
   logic        z_valid, z_last, z_busy;
   logic [15:0] z_data;
   logic [1:0]  z_idx;

   param_table_seq #(.NUM_CH(4), .WIDTH(4), .DEPTH(4),
                     .TABLE(64'hFEDC_BA98_7654_3210)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .idx(idx), .busy(busy));

   param_table_seq #(.NUM_CH(4), .WIDTH(4), .DEPTH(1),
                     .TABLE(16'hA5C3)) u_dut_d1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .abort(abort), .loop_en(loop_en),
      .out_valid(d1_valid), .out_ready(out_ready), .out_data(d1_data),
      .out_last(d1_last), .idx(d1_idx), .busy(d1_busy));

   param_table_seq #(.NUM_CH(4), .WIDTH(4), .DEPTH(4)) u_dut_zero (
      .clk(clk), .rst_n(rst_n), .start(s0), .abort(abort), .loop_en(loop_en),
      .out_valid(z_valid), .out_ready(out_ready), .out_data(z_data),
      .out_last(z_last), .idx(z_idx), .busy(z_busy));

   logic [15:0] tbl [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model of the main instance: where in the table we are.
   bit          m_busy = 1'b0;
   int          m_idx  = 0;
   logic [15:0] m_data = '0;

   task automatic model_reset();
      m_busy = 1'b0;
      m_idx  = 0;
      m_data = '0;
   endtask

   // Apply the sequencing rules for one clock edge using the pre-edge inputs.
   task automatic model_step();
      if (!m_busy) begin
         if (start && !abort) begin
            m_busy = 1'b1;
            m_idx  = 0;
            m_data = tbl[0];
         end
      end else begin
         if (out_ready) begin
            if (m_idx < 3) begin
               m_idx  = m_idx + 1;
               m_data = tbl[m_idx];
            end else if (loop_en) begin
               m_idx  = 0;
               m_data = tbl[0];
            end else begin
               m_busy = 1'b0;
            end
         end
         if (abort) m_busy = 1'b0;
      end
   endtask

   // One clock edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({out_valid, busy, out_last, idx, out_data} !== 21'h0) begin
         $display("FAIL reset_state: valid=%b busy=%b last=%b idx=%0d data=%h, want all zero",
                  out_valid, busy, out_last, idx, out_data);
      end else n_pass++;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      start = 1'b1; out_ready = 1'b1; loop_en = 1'b0;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== tbl[i] || idx !== 2'(i) || out_last !== (i == 3)) begin
            $display("FAIL basic_beat%0d: valid=%b data=%h idx=%0d last=%b, want 1 %h %0d %b",
                     i, out_valid, out_data, idx, out_last, tbl[i], i, (i == 3));
         end else n_pass++;
         step();
      end
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL basic_end: valid=%b busy=%b, want 0 0", out_valid, busy);
      end else n_pass++;
   endtask

   task automatic test_backpressure();
      start = 1'b1; out_ready = 1'b1; loop_en = 1'b0;
      step();
      start = 1'b0;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 16'h7654 || idx !== 2'd1 || out_last !== 1'b0) begin
            $display("FAIL backpressure_hold%0d: valid=%b data=%h idx=%0d last=%b, want 1 7654 1 0",
                     i, out_valid, out_data, idx, out_last);
         end else n_pass++;
      end
      out_ready = 1'b1;
      step();
      n_checks++;
      if (out_data !== 16'hBA98 || idx !== 2'd2) begin
         $display("FAIL backpressure_resume: data=%h idx=%0d, want BA98 2", out_data, idx);
      end else n_pass++;
      step();
      n_checks++;
      if (out_data !== 16'hFEDC || out_last !== 1'b1) begin
         $display("FAIL backpressure_last: data=%h last=%b, want FEDC 1", out_data, out_last);
      end else n_pass++;
      step();
   endtask

   task automatic test_loop();
      start = 1'b1; out_ready = 1'b1; loop_en = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         n_checks++;
         if (busy !== 1'b1 || out_data !== tbl[k % 4] || out_last !== ((k % 4) == 3)) begin
            $display("FAIL loop_beat%0d: busy=%b data=%h last=%b, want 1 %h %b",
                     k, busy, out_data, out_last, tbl[k % 4], ((k % 4) == 3));
         end else n_pass++;
         step();
      end
      loop_en = 1'b0;
      step();
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL loop_exit: valid=%b, want 0", out_valid);
      end else n_pass++;
   endtask

   task automatic test_abort();
      start = 1'b1; out_ready = 1'b1; loop_en = 1'b0;
      step();
      start = 1'b0;
      step();
      step();
      n_checks++;
      if (out_data !== 16'hBA98 || idx !== 2'd2) begin
         $display("FAIL abort_pre: data=%h idx=%0d, want BA98 2", out_data, idx);
      end else n_pass++;
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL abort_idle: valid=%b busy=%b, want 0 0", out_valid, busy);
      end else n_pass++;
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         $display("FAIL start_abort_idle: busy=%b valid=%b, want 0 0", busy, out_valid);
      end else n_pass++;
   endtask

   task automatic test_reset_mid();
      start = 1'b1; out_ready = 1'b1; loop_en = 1'b0;
      step();
      start = 1'b0;
      repeat (3) step();
      n_checks++;
      if (idx !== 2'd3 || out_data !== 16'hFEDC) begin
         $display("FAIL reset_mid_pre: idx=%0d data=%h, want 3 FEDC", idx, out_data);
      end else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || idx !== 2'd0 || out_data !== 16'h0 || out_last !== 1'b0) begin
         $display("FAIL reset_mid_clear: valid=%b busy=%b idx=%0d data=%h last=%b, want all zero",
                  out_valid, busy, idx, out_data, out_last);
      end else n_pass++;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h3210 || idx !== 2'd0) begin
         $display("FAIL reset_mid_restart: valid=%b data=%h idx=%0d, want 1 3210 0",
                  out_valid, out_data, idx);
      end else n_pass++;
      repeat (4) step();
   endtask

   task automatic test_depth1();
      out_ready = 1'b1; loop_en = 1'b0;
      s1 = 1'b1;
      step();
      s1 = 1'b0;
      n_checks++;
      if (d1_valid !== 1'b1 || d1_data !== 16'hA5C3 || d1_last !== 1'b1 || d1_idx !== 1'b0) begin
         $display("FAIL depth1_beat: valid=%b data=%h last=%b idx=%0d, want 1 A5C3 1 0",
                  d1_valid, d1_data, d1_last, d1_idx);
      end else n_pass++;
      step();
      n_checks++;
      if (d1_valid !== 1'b0) begin
         $display("FAIL depth1_end: valid=%b, want 0", d1_valid);
      end else n_pass++;
      loop_en = 1'b1;
      s1 = 1'b1;
      step();
      s1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if (d1_valid !== 1'b1 || d1_data !== 16'hA5C3 || d1_last !== 1'b1) begin
            $display("FAIL depth1_loop%0d: valid=%b data=%h last=%b, want 1 A5C3 1",
                     k, d1_valid, d1_data, d1_last);
         end else n_pass++;
      end
      loop_en = 1'b0;
      step();
      n_checks++;
      if (d1_valid !== 1'b0) begin
         $display("FAIL depth1_loop_exit: valid=%b, want 0", d1_valid);
      end else n_pass++;
   endtask

   task automatic test_default_table();
      out_ready = 1'b1; loop_en = 1'b0;
      s0 = 1'b1;
      step();
      s0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (z_valid !== 1'b1 || z_data !== 16'h0000 || z_idx !== 2'(i)) begin
            $display("FAIL zero_table%0d: valid=%b data=%h idx=%0d, want 1 0000 %0d",
                     i, z_valid, z_data, z_idx, i);
         end else n_pass++;
         step();
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 600; c++) begin
         start     = ($urandom_range(0, 3) == 0);
         abort     = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         loop_en   = $urandom_range(0, 1);
         step();
         n_checks++;
         if (out_valid !== m_busy || busy !== m_busy || out_last !== (m_busy && m_idx == 3) ||
             (m_busy && (idx !== 2'(m_idx) || out_data !== m_data))) begin
            if (bad < 10) begin
               $display("FAIL random_c%0d: valid=%b idx=%0d data=%h last=%b, want %b %0d %h %b",
                        c, out_valid, idx, out_data, out_last, m_busy, m_idx, m_data,
                        (m_busy && m_idx == 3));
            end
            bad++;
         end else n_pass++;
      end
      start = 1'b0; abort = 1'b0; loop_en = 1'b0; out_ready = 1'b1;
      repeat (5) step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_loop();
      test_abort();
      test_reset_mid();
      test_depth1();
      test_default_table();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
